uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio_if.sv | 13 +
 rtl/uart_tx_mmio.sv | 139 +++++++++++++
 tb/tb_uart_tx_mmio.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_if.sv
// CPU data-port bus for the memory-mapped UART transmitter.
`timescale 1ns/1ps
interface uart_tx_mmio_if;
  logic        sel_i;
  logic        strobe_i;
  logic        wr_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output sel_i, strobe_i, wr_i, addr_i, wdata_i, input rdata_o);
  modport slave  (input sel_i, strobe_i, wr_i, addr_i, wdata_i, output rdata_o);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable baud divisor, drain interrupt.
// Reads return registered data one cycle after the access edge and never change state.
`timescale 1ns/1ps
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_mmio_if.slave bus,
  output logic         tx_o,
  output logic         irq_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_ovf, r_enable, r_ie, r_irq, r_tx;
  logic [15:0]   r_div, r_div_lat, r_timer;
  logic [31:0]   r_rdata;
  logic [1:0]    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_idx;

  logic        w_acc, w_wr, w_rd, w_push_req, w_push, w_pop;
  logic        w_full, w_empty, w_busy, w_wrap;
  logic [1:0]  w_reg;
  logic [31:0] w_rmux;
  logic        w_unused;

  assign w_acc      = bus.sel_i & bus.strobe_i;
  assign w_wr       = w_acc & bus.wr_i;
  assign w_rd       = w_acc & ~bus.wr_i;
  assign w_reg      = bus.addr_i[3:2];
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = w_wr & (w_reg == 2'd0);
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & r_enable & ~w_empty;
  assign w_wrap     = (r_timer == r_div_lat);
  assign w_unused   = ^{bus.addr_i[1:0], bus.wdata_i[31:16]};

  always_comb begin
    w_rmux = 32'h0;
    case (w_reg)
      2'd1:    w_rmux = {16'h0, 8'(r_level), 4'h0, r_ovf, w_empty, w_full, w_busy};
      2'd2:    w_rmux = {16'h0, r_div};
      2'd3:    w_rmux = {30'h0, r_ie, r_enable};
      default: w_rmux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.wdata_i[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= 32'h0;
      r_div    <= DEFAULT_DIV;
      r_enable <= 1'b0;
      r_ie     <= 1'b0;
      r_ovf    <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_rmux;
      if (w_wr && w_reg == 2'd2) r_div <= bus.wdata_i[15:0];
      if (w_wr && w_reg == 2'd3) begin
        r_enable <= bus.wdata_i[0];
        r_ie     <= bus.wdata_i[1];
      end
      // A dropped push sets overflow even if a clear arrives the same cycle.
      if (w_push_req && w_full)                          r_ovf <= 1'b1;
      else if (w_wr && w_reg == 2'd1 && bus.wdata_i[3])  r_ovf <= 1'b0;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      r_irq <= r_ie & w_empty & (r_state == S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_timer   <= 16'h0;
      r_div_lat <= 16'h0;
      r_shift   <= 8'h0;
      r_idx     <= 3'd0;
    end else if (r_state == S_IDLE) begin
      if (w_pop) begin
        r_shift   <= r_mem[r_rptr];
        r_div_lat <= r_div;
        r_timer   <= 16'h0;
        r_state   <= S_START;
        r_tx      <= 1'b0;
      end
    end else begin
      // Bit-timer counts 0..DIV; its wrap ends the current bit period.
      r_timer <= w_wrap ? 16'h0 : r_timer + 16'd1;
      if (w_wrap) begin
        case (r_state)
          S_START: begin
            r_tx    <= r_shift[0];
            r_idx   <= 3'd0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            if (r_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rdata_o = r_rdata;
  assign tx_o        = r_tx;
  assign irq_o       = r_irq;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, framing, overflow, mid-frame changes, irq, reset.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, irq;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave),
    .tx_o  (tx),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the access lands on the next rising edge.
  task automatic bus_acc(input logic sel, input logic wr, input logic [3:0] a,
                         input logic [31:0] d, output logic [31:0] rd);
    bus_if.sel_i    = sel;
    bus_if.strobe_i = 1'b1;
    bus_if.wr_i     = wr;
    bus_if.addr_i   = a;
    bus_if.wdata_i  = d;
    @(posedge clk);
    @(negedge clk);
    bus_if.sel_i    = 1'b0;
    bus_if.strobe_i = 1'b0;
    bus_if.wr_i     = 1'b0;
    rd = bus_if.rdata_o;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_acc(1'b1, 1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_acc(1'b1, 1'b0, a, 32'h0, v);
    check(tag, v, exp);
  endtask

  // Waits for a start bit, then samples every cycle of a 10-bit frame.
  task automatic rx_frame(input int cpb, output logic [7:0] b, output int waited, output bit ok);
    int bitn;
    ok = 1'b1;
    waited = 0;
    b = 8'h00;
    do begin
      @(negedge clk);
      waited++;
    end while (tx !== 1'b0 && waited < 3000);
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < 10 * cpb; i++) begin
      if (i > 0) @(negedge clk);
      bitn = i / cpb;
      if (bitn == 0) begin
        if (tx !== 1'b0) ok = 1'b0;
      end else if (bitn == 9) begin
        if (tx !== 1'b1) ok = 1'b0;
      end else if (i % cpb == 0) begin
        b[bitn-1] = tx;
      end else if (tx !== b[bitn-1]) begin
        ok = 1'b0;
      end
    end
  endtask

  task automatic quiet(input int n, output bit q);
    q = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) q = 1'b0;
    end
  endtask

  logic [7:0]  b1, b2;
  int          w1, w2;
  bit          ok1, ok2, q;
  logic [31:0] dummy;

  initial begin
    bus_if.sel_i    = 1'b0;
    bus_if.strobe_i = 1'b0;
    bus_if.wr_i     = 1'b0;
    bus_if.addr_i   = 4'h0;
    bus_if.wdata_i  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", bus_if.rdata_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("rst_status", 4'h4, 32'h0000_0004);
    rd_chk("rst_div", 4'h8, 32'd433);
    rd_chk("rst_ctrl", 4'hC, 32'h0);
    rd_chk("rd_txdata", 4'h0, 32'h0);
    bus_acc(1'b0, 1'b1, 4'h0, 32'h77, dummy);
    rd_chk("nosel_status", 4'h4, 32'h0000_0004);

    // Single frame at 4 cycles/bit
    wr_reg(4'h8, 32'd3);
    wr_reg(4'hC, 32'h1);
    wr_reg(4'h0, 32'h55);
    check("lat_pre", {31'h0, tx}, 32'h1);
    rx_frame(4, b1, w1, ok1);
    check("f55_ok", {31'h0, ok1}, 32'h1);
    check("f55_data", {24'h0, b1}, 32'h55);
    check("f55_latency", w1, 32'd1);
    @(negedge clk);
    rd_chk("f55_idle", 4'h4, 32'h0000_0004);
    rd_chk("div_rb", 4'h8, 32'd3);

    // Overflow with transmitter disabled
    wr_reg(4'hC, 32'h0);
    for (int i = 1; i <= 9; i++) wr_reg(4'h0, 32'(i));
    rd_chk("ovf_status", 4'h4, 32'h0000_080A);
    wr_reg(4'h4, 32'h8);
    rd_chk("ovf_clr", 4'h4, 32'h0000_0802);
    wr_reg(4'hC, 32'h1);
    for (int k = 0; k < 8; k++) begin
      rx_frame(4, b1, w1, ok1);
      check($sformatf("drain%0d_ok", k), {31'h0, ok1}, 32'h1);
      check($sformatf("drain%0d_data", k), {24'h0, b1}, 32'(k + 1));
    end
    quiet(60, q);
    check("no_byte9", {31'h0, q}, 32'h1);
    rd_chk("drain_status", 4'h4, 32'h0000_0004);

    // Divisor change mid-frame only affects the next frame
    wr_reg(4'hC, 32'h0);
    wr_reg(4'h0, 32'h3C);
    wr_reg(4'h0, 32'hC3);
    fork
      begin
        wr_reg(4'hC, 32'h1);
        repeat (10) @(negedge clk);
        wr_reg(4'h8, 32'd1);
      end
      begin
        rx_frame(4, b1, w1, ok1);
        rx_frame(2, b2, w2, ok2);
      end
    join
    check("div_old_ok", {31'h0, ok1}, 32'h1);
    check("div_old_data", {24'h0, b1}, 32'h3C);
    check("div_new_ok", {31'h0, ok2}, 32'h1);
    check("div_new_data", {24'h0, b2}, 32'hC3);

    // Clearing enable mid-frame finishes the frame and keeps the FIFO
    wr_reg(4'h8, 32'd3);
    wr_reg(4'hC, 32'h0);
    wr_reg(4'h0, 32'h11);
    wr_reg(4'h0, 32'h22);
    fork
      begin
        wr_reg(4'hC, 32'h1);
        repeat (8) @(negedge clk);
        wr_reg(4'hC, 32'h0);
      end
      rx_frame(4, b1, w1, ok1);
    join
    check("dis_ok", {31'h0, ok1}, 32'h1);
    check("dis_data", {24'h0, b1}, 32'h11);
    quiet(60, q);
    check("dis_quiet", {31'h0, q}, 32'h1);
    rd_chk("dis_level", 4'h4, 32'h0000_0100);

    // Read-modify-write store to TXDATA pushes exactly once
    rd_chk("rmw_rd", 4'h0, 32'h0);
    wr_reg(4'h0, 32'h0000_00A5);
    rd_chk("rmw_level", 4'h4, 32'h0000_0200);
    wr_reg(4'hC, 32'h1);
    rx_frame(4, b1, w1, ok1);
    rx_frame(4, b2, w2, ok2);
    check("rmw_f1", {23'h0, ok1, b1}, 32'h122);
    check("rmw_f2", {23'h0, ok2, b2}, 32'h1A5);
    @(negedge clk);
    rd_chk("rmw_empty", 4'h4, 32'h0000_0004);

    // Interrupt follows drain
    wr_reg(4'hC, 32'h3);
    repeat (2) @(negedge clk);
    check("irq_idle", {31'h0, irq}, 32'h1);
    wr_reg(4'h0, 32'h96);
    fork
      rx_frame(4, b1, w1, ok1);
      begin
        repeat (20) @(negedge clk);
        check("irq_busy", {31'h0, irq}, 32'h0);
      end
    join
    check("irq_frame", {23'h0, ok1, b1}, 32'h196);
    repeat (2) @(negedge clk);
    check("irq_drained", {31'h0, irq}, 32'h1);

    // Async reset in the middle of the data bits
    wr_reg(4'h0, 32'h00);
    repeat (10) @(negedge clk);
    check("pre_rst_tx", {31'h0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'h0, tx}, 32'h1);
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("post_rst_status", 4'h4, 32'h0000_0004);
    rd_chk("post_rst_div", 4'h8, 32'd433);
    rd_chk("post_rst_ctrl", 4'hC, 32'h0);
    quiet(30, q);
    check("post_rst_quiet", {31'h0, q}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
